// File: rtl/sync_delay_ctrl.sv
// Programmable ring-buffer delay for the {de, vsync, hsync} bundle with handshaked, blanked depth changes.
// Optional macro SYNC_DELAY_FRAME_LOCK_EN defers depth changes to the next vsync falling edge.
module sync_delay_ctrl #(
  parameter int              WIDTH         = 3,
  parameter int              MAX_DELAY     = 16,
  parameter int              DELAY_W       = 5,
  parameter int              DEFAULT_DELAY = 4,
  parameter int              VSYNC_BIT     = 1,
  parameter logic [WIDTH-1:0] BLANK        = WIDTH'(3'b011)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   signal_in,
  output logic [WIDTH-1:0]   signal_out,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic [DELAY_W-1:0] active_delay,
  output logic               locked
);

  localparam int PTR_W = $clog2(MAX_DELAY);
  // An illegal parameter set never leaves FILL, so misconfiguration is visible immediately.
  localparam bit PARAMS_OK = (MAX_DELAY == (1 << PTR_W)) && (DELAY_W >= $clog2(MAX_DELAY + 1)) &&
                             (VSYNC_BIT < WIDTH) && (DEFAULT_DELAY >= 1) && (DEFAULT_DELAY <= MAX_DELAY);

  typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_PEND} state_t;

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [DELAY_W-1:0] active_q, active_d;
  logic [DELAY_W-1:0] pend_q, pend_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               locked_q, locked_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   mem_q [MAX_DELAY];
  logic [DELAY_W-1:0] req_clamped;
  logic [PTR_W-1:0]   rd_ptr;
  logic               apply;

`ifdef SYNC_DELAY_FRAME_LOCK_EN
  logic vs_prev_q, vs_prev_d;
  always_comb begin
    vs_prev_d = signal_in[VSYNC_BIT];
    apply     = vs_prev_q & ~signal_in[VSYNC_BIT];
  end
  always_ff @(posedge clk) begin
    if (rst) vs_prev_q <= 1'b1;
    else     vs_prev_q <= vs_prev_d;
  end
`else
  always_comb apply = 1'b1;
`endif

  always_comb begin
    if (cfg_delay == '0)                          req_clamped = DELAY_W'(1);
    else if (cfg_delay > DELAY_W'(MAX_DELAY))     req_clamped = DELAY_W'(MAX_DELAY);
    else                                          req_clamped = cfg_delay;
  end

  // D = MAX_DELAY wraps to rd_ptr == wr_ptr: the slot read before this cycle's write.
  assign rd_ptr = wr_ptr_q - active_q[PTR_W-1:0];

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    active_d   = active_q;
    pend_d     = pend_q;
    wr_ptr_d   = wr_ptr_q + PTR_W'(1);
    case (state_q)
      ST_FILL: begin
        fill_cnt_d = fill_cnt_q + DELAY_W'(1);
        if (PARAMS_OK && (fill_cnt_q == active_q - DELAY_W'(1))) begin
          state_d    = ST_RUN;
          fill_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (cfg_valid && ready_q && (req_clamped != active_q)) begin
          pend_d  = req_clamped;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (apply) begin
          active_d   = pend_q;
          fill_cnt_d = '0;
          state_d    = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
    out_d    = (state_q == ST_FILL) ? BLANK : mem_q[rd_ptr];
    locked_d = (state_q != ST_FILL);
    ready_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= '0;
      active_q   <= DELAY_W'(DEFAULT_DELAY);
      pend_q     <= '0;
      wr_ptr_q   <= '0;
      out_q      <= BLANK;
      locked_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      out_q      <= out_d;
      locked_q   <= locked_d;
      ready_q    <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q[wr_ptr_q] <= signal_in;
  end

  assign signal_out   = out_q;
  assign locked       = locked_q;
  assign cfg_ready    = ready_q;
  assign active_delay = active_q;

endmodule

// File: tb/tb_sync_delay_ctrl.sv
// Directed bench for sync_delay_ctrl: lock-up, tracking across wrap, clamping, no-op, reset during PENDING.
module tb_sync_delay_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] signal_in;
  logic [2:0] signal_out;
  logic [4:0] cfg_delay;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [4:0] active_delay;
  logic       locked;

  logic [2:0] hist [4096];
  int         e_next;
  int         e_last;
  logic       vs_lvl;
  int         vec_cnt;
  int         err_cnt;

  localparam logic [2:0] BLANK_V = 3'b011;

  sync_delay_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .signal_in    (signal_in),
    .signal_out   (signal_out),
    .cfg_delay    (cfg_delay),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .active_delay (active_delay),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e_last);
    end
  endtask

  // Drive a fresh sample, remember what the DUT captures, then sample 1ns after the edge.
  task automatic step();
    signal_in = {1'($urandom_range(0, 1)), vs_lvl, 1'($urandom_range(0, 1))};
    hist[e_next & 4095] = signal_in;
    @(posedge clk);
    #1;
    e_last = e_next;
    e_next++;
  endtask

  task automatic track(input int n, input int d);
    for (int i = 0; i < n; i++) begin
      step();
      check("trk_locked", locked, 1);
      check("trk_out", signal_out, hist[(e_last - d) & 4095]);
    end
  endtask

  task automatic lockup();
    rst = 1'b1;
    step();
    check("rst_out", signal_out, BLANK_V);
    check("rst_locked", locked, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_active", active_delay, 4);
    rst    = 1'b0;
    e_next = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fill_locked", locked, 0);
      check("fill_out", signal_out, BLANK_V);
    end
    step();
    check("lock_edge", locked, 1);
    check("lock_first", signal_out, hist[0]);
    check("lock_ready", cfg_ready, 1);
  endtask

  task automatic request(input logic [4:0] val, input int newd, input int oldd);
    int a;
    check("req_ready_pre", cfg_ready, 1);
    cfg_delay = val;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    if (newd == oldd) begin
      check("noop_ready", cfg_ready, 1);
      check("noop_active", active_delay, oldd);
      track(6, oldd);
      check("noop_ready_hold", cfg_ready, 1);
    end else begin
      check("pend_ready", cfg_ready, 0);
      check("pend_locked", locked, 1);
      check("pend_out", signal_out, hist[(e_last - oldd) & 4095]);
`ifdef SYNC_DELAY_FRAME_LOCK_EN
      for (int i = 0; i < 3; i++) begin
        step();
        check("pend_hold_active", active_delay, oldd);
        check("pend_hold_locked", locked, 1);
      end
      vs_lvl = 1'b0;
      step();
      vs_lvl = 1'b1;
`else
      step();
`endif
      a = e_last;
      check("apply_active", active_delay, newd);
      check("apply_locked", locked, 1);
      check("apply_out", signal_out, hist[(a - oldd) & 4095]);
      for (int i = 0; i < newd; i++) begin
        step();
        check("refill_locked", locked, 0);
        check("refill_out", signal_out, BLANK_V);
      end
      step();
      check("relock", locked, 1);
      check("relock_first", signal_out, hist[(a + 1) & 4095]);
      check("relock_ready", cfg_ready, 1);
      track(20, newd);
    end
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    e_next    = 0;
    e_last    = 0;
    vs_lvl    = 1'b1;
    rst       = 1'b1;
    signal_in = 3'b011;
    cfg_delay = '0;
    cfg_valid = 1'b0;
    repeat (2) step();

    lockup();
    track(20, 4);
    request(5'd4, 4, 4);
    request(5'd16, 16, 4);
    request(5'd0, 1, 16);
    request(5'd31, 16, 1);
    request(5'd4, 4, 16);

`ifdef SYNC_DELAY_FRAME_LOCK_EN
    // Accept coinciding with a vsync fall must wait for the following fall.
    cfg_delay = 5'd8;
    cfg_valid = 1'b1;
    vs_lvl    = 1'b0;
    step();
    cfg_valid = 1'b0;
    vs_lvl    = 1'b1;
    check("coin_ready", cfg_ready, 0);
    check("coin_active", active_delay, 4);
    for (int i = 0; i < 3; i++) begin
      step();
      check("coin_hold", active_delay, 4);
      check("coin_locked", locked, 1);
    end
    vs_lvl = 1'b0;
    step();
    vs_lvl = 1'b1;
    check("coin_apply", active_delay, 8);
    for (int i = 0; i < 8; i++) begin
      step();
      check("coin_refill", locked, 0);
    end
    track(10, 8);
`endif

    // Reset while a request is pending discards it.
    cfg_delay = 5'd8;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("rstp_ready", cfg_ready, 0);
    lockup();
    check("rstp_active", active_delay, 4);
    track(24, 4);
    check("rstp_active_end", active_delay, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
